nec_ir_rx: RTL and testbench
============================

Name: nec_ir_rx

Overview:
- Front-end decoder for the IR receiver pin, running on the 48 MHz system clock.
- Samples the active-low demodulated NEC signal, measures pulse widths with a 1 us timebase and assembles the 32-bit frame.
- Checks the command/inverse pair and presents the command byte to the display logic with a one-cycle valid strobe.
- Sits between the IRDA pin and the top-level code register that drives the 4-digit tube.

Parameters:
- CLK_HZ, 48000000, system clock frequency; prescaler divides to a 1 us tick (CLK_HZ/1000000 must be an integer >= 2).
- FILT_LEN, 4, consecutive equal 1 us samples needed to accept a level change (glitch filter).
- W_CNT, 14, width of the saturating pulse-width counter in us.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ir  in  1  raw receiver output; idle high, burst = low
- code  out  8  last valid command byte
- addr  out  8  last valid address byte
- valid  out  1  one-clk pulse when code/addr update
- rpt  out  1  one-clk pulse on a valid repeat frame (see Optional Feature)
- err  out  1  one-clk pulse on any framing or checksum failure
- busy  out  1  high while FSM is not in IDLE

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, FSM IDLE, filter state = 1, counters 0, prescaler 0.
- Input path: 2-flop synchronizer; prescaler makes tick every CLK_HZ/1e6 clocks. Filtered level changes only after FILT_LEN consecutive ticks at the new value.
- Width counter: cleared on every filtered edge, +1 per tick, saturates at 2^W_CNT-1. The "width" of a phase is the count latched at the edge that ends it.
- FSM states: IDLE, LEAD_L, LEAD_H, BIT_L, BIT_H, STOP_L.
  - IDLE: on falling edge -> LEAD_L.
  - LEAD_L: on rising edge, width 8000..10000 -> LEAD_H, else err -> IDLE.
  - LEAD_H: on falling edge:
    - width 4000..5000 -> BIT_L, with bit index = 0.
    - width 2000..2500 -> STOP_L with repeat flag set.
    - otherwise err -> IDLE.
  - BIT_L: on rising edge, width 400..700 -> BIT_H, else err.
  - BIT_H: on falling edge:
    - width 400..700 -> shift in 0; width 1400..1900 -> shift in 1; otherwise err.
    - Bits arrive LSB first, order addr, ~addr, cmd, ~cmd.
    - After bit 31 -> STOP_L; else -> BIT_L.
  - STOP_L: on rising edge, width 400..700:
    - Data frame: if cmd == ~cmd_inv, load code/addr and pulse valid; else pulse err. Address inverse is not checked (extended-address remotes).
    - Repeat frame: handled per Optional Feature.
    - Stop width out of range: err.
    - All cases -> IDLE.
- Timeout: in any non-IDLE state, width reaching 12000 without an edge -> err pulse, -> IDLE. An idle-high line never produces err.
- Simultaneous events: the timeout check takes priority over edge decode in the same tick. valid and err are never both asserted.
- code/addr hold their values across errors and repeats; only valid updates them.
- Latency: valid asserts 1–2 clk after the tick on which the filtered stop-bit rising edge is seen (FILT_LEN us after the physical edge plus sync delay).
- Reset mid-frame discards the shift register. The next frame is decoded only from a fresh falling edge.

Optional Feature:
- Macro: IR_REPEAT_EN.
- Defined: a repeat frame in STOP_L pulses rpt, but only if a valid data frame completed within the last 110 ms. A 17-bit ms counter is cleared on valid and saturates; stale repeats pulse err instead.
- Undefined: rpt tied 0, the ms counter is removed, and repeat frames return to IDLE silently (no err).

Decomposition:
- Package nec_ir_pkg holds:
  - state enum;
  - us limits: LEAD_L_MIN/MAX, LEAD_H_MIN/MAX, RPT_H_MIN/MAX, BIT_MIN/MAX, ONE_MIN/MAX, TIMEOUT_US, RPT_WINDOW_MS.
- Sub-module ir_edge_filter: synchronizer + prescaler tick + glitch filter. Outputs: tick, level, rise, fall.
- Top FSM and shift register remain in nec_ir_rx.

Test Plan:
- Data frame, addr=0x00, cmd=0x45, nominal timing -> single valid pulse, code=0x45, addr=0x00, err=0, busy low after stop bit.
- Same frame with ~cmd byte corrupted to 0xBB -> err pulse, no valid, code keeps its previous value.
- 300 ns and 2 us low glitches on an idle line -> no state change, busy stays 0, no err.
- IR_REPEAT_EN:
  - Repeat frame (9 ms / 2.25 ms / 560 us) 40 ms after valid -> rpt pulse, code unchanged.
  - Same repeat 200 ms after valid -> err pulse.
- Line held low 15 ms after leader -> err at 12 ms of low; then a nominal frame with cmd=0x16 decodes correctly.
- Assert rst during bit 20 -> all outputs 0 immediately; next full frame with cmd=0x0C -> code=0x0C, valid pulses once.

Source files
------------

// File: rtl/nec_ir_pkg.sv
// Shared state encoding and pulse-width limits (in microseconds) for the NEC IR receiver.
package nec_ir_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_L,
    S_LEAD_H,
    S_BIT_L,
    S_BIT_H,
    S_STOP_L
  } state_t;

  localparam int LEAD_L_MIN    = 8000;
  localparam int LEAD_L_MAX    = 10000;
  localparam int LEAD_H_MIN    = 4000;
  localparam int LEAD_H_MAX    = 5000;
  localparam int RPT_H_MIN     = 2000;
  localparam int RPT_H_MAX     = 2500;
  localparam int BIT_MIN       = 400;
  localparam int BIT_MAX       = 700;
  localparam int ONE_MIN       = 1400;
  localparam int ONE_MAX       = 1900;
  localparam int TIMEOUT_US    = 12000;
  localparam int RPT_WINDOW_MS = 110;

  function automatic logic in_range(input int w, input int lo, input int hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/ir_edge_filter.sv
// IR pin conditioning: 2-flop synchronizer, 1 us tick prescaler and a FILT_LEN-tick glitch filter.
module ir_edge_filter #(
  parameter int CLK_HZ   = 48000000,
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ir,
  output logic tick,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int DIV = CLK_HZ / 1000000;
  localparam int PW  = $clog2(DIV);
  localparam int FW  = $clog2(FILT_LEN + 1);

  logic          sync_p0, sync_p1;
  logic [PW-1:0] pre;
  logic [FW-1:0] run;

  assign tick = (pre == PW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      pre     <= '0;
      run     <= '0;
      level   <= 1'b1;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync_p0 <= ir;
      sync_p1 <= sync_p0;
      pre     <= tick ? '0 : pre + PW'(1);
      rise    <= 1'b0;
      fall    <= 1'b0;
      // Level flips only on the FILT_LEN-th consecutive tick that disagrees with it.
      if (tick) begin
        if (sync_p1 == level) begin
          run <= '0;
        end else if (run == FW'(FILT_LEN - 1)) begin
          run   <= '0;
          level <= sync_p1;
          rise  <= sync_p1;
          fall  <= ~sync_p1;
        end else begin
          run <= run + FW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/nec_ir_rx.sv
// NEC IR frame decoder: pulse-width FSM, 32-bit shift register and command check.
// Define IR_REPEAT_EN to decode repeat frames within a 110 ms window after a valid frame.
module nec_ir_rx
  import nec_ir_pkg::*;
#(
  parameter int CLK_HZ   = 48000000,
  parameter int FILT_LEN = 4,
  parameter int W_CNT    = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir,
  output logic [7:0] code,
  output logic [7:0] addr,
  output logic       valid,
  output logic       rpt,
  output logic       err,
  output logic       busy
);

  logic             tick, level, rise, fall, edge_any, rpt_ok, timeout;
  logic [W_CNT-1:0] width;
  state_t           state;
  logic [31:0]      shreg;
  logic [4:0]       bit_idx;
  logic             rpt_frame;
  int               w;

  ir_edge_filter #(.CLK_HZ(CLK_HZ), .FILT_LEN(FILT_LEN)) u_filt (
    .clk   (clk),
    .rst   (rst),
    .ir    (ir),
    .tick  (tick),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign edge_any = rise | fall;
  assign w        = int'(width);
  assign timeout  = (w >= TIMEOUT_US);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width <= '0;
    end else if (edge_any) begin
      width <= '0;
    end else if (tick && (width != '1)) begin
      width <= width + W_CNT'(1);
    end
  end

`ifdef IR_REPEAT_EN
  localparam bit RPT_EN = 1'b1;
  logic [9:0]  us_cnt;
  logic [16:0] ms_cnt;
  logic        seen_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      us_cnt     <= '0;
      ms_cnt     <= '0;
      seen_valid <= 1'b0;
    end else if (valid) begin
      us_cnt     <= '0;
      ms_cnt     <= '0;
      seen_valid <= 1'b1;
    end else if (tick) begin
      if (us_cnt == 10'd999) begin
        us_cnt <= '0;
        if (ms_cnt != '1) ms_cnt <= ms_cnt + 17'd1;
      end else begin
        us_cnt <= us_cnt + 10'd1;
      end
    end
  end

  assign rpt_ok = seen_valid && (int'(ms_cnt) < RPT_WINDOW_MS);
`else
  localparam bit RPT_EN = 1'b0;
  assign rpt_ok = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      rpt_frame <= 1'b0;
      code      <= '0;
      addr      <= '0;
      valid     <= 1'b0;
      rpt       <= 1'b0;
      err       <= 1'b0;
    end else begin
      valid <= 1'b0;
      rpt   <= 1'b0;
      err   <= 1'b0;
      // A stuck phase aborts the frame before any edge decode is considered.
      if ((state != S_IDLE) && timeout) begin
        err   <= 1'b1;
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (edge_any && !level) begin
            state     <= S_LEAD_L;
            rpt_frame <= 1'b0;
          end
          S_LEAD_L: if (edge_any && level) begin
            if (in_range(w, LEAD_L_MIN, LEAD_L_MAX)) state <= S_LEAD_H;
            else begin err <= 1'b1; state <= S_IDLE; end
          end
          S_LEAD_H: if (edge_any && !level) begin
            if (in_range(w, LEAD_H_MIN, LEAD_H_MAX)) begin
              state   <= S_BIT_L;
              bit_idx <= '0;
            end else if (in_range(w, RPT_H_MIN, RPT_H_MAX)) begin
              state     <= S_STOP_L;
              rpt_frame <= 1'b1;
            end else begin
              err   <= 1'b1;
              state <= S_IDLE;
            end
          end
          S_BIT_L: if (edge_any && level) begin
            if (in_range(w, BIT_MIN, BIT_MAX)) state <= S_BIT_H;
            else begin err <= 1'b1; state <= S_IDLE; end
          end
          S_BIT_H: if (edge_any && !level) begin
            if (in_range(w, BIT_MIN, BIT_MAX) || in_range(w, ONE_MIN, ONE_MAX)) begin
              shreg   <= {in_range(w, ONE_MIN, ONE_MAX), shreg[31:1]};
              bit_idx <= bit_idx + 5'd1;
              state   <= (bit_idx == 5'd31) ? S_STOP_L : S_BIT_L;
            end else begin
              err   <= 1'b1;
              state <= S_IDLE;
            end
          end
          S_STOP_L: if (edge_any && level) begin
            state <= S_IDLE;
            if (!in_range(w, BIT_MIN, BIT_MAX)) begin
              err <= 1'b1;
            end else if (rpt_frame) begin
              if (RPT_EN && rpt_ok) rpt <= 1'b1;
              else if (RPT_EN) err <= 1'b1;
            end else if (shreg[23:16] == ~shreg[31:24]) begin
              code  <= shreg[23:16];
              addr  <= shreg[7:0];
              valid <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nec_ir_rx.sv
// Directed bench for nec_ir_rx: drives NEC waveforms in real time and scoreboards valid/err/rpt strobes.
`timescale 1ns/1ps
module tb_nec_ir_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ir  = 1'b1;
  logic [7:0] code, addr;
  logic       valid, rpt, err, busy;

  typedef struct packed {
    logic [2:0] flags;
    logic [7:0] code;
    logic [7:0] addr;
  } ev_t;

  localparam logic [2:0] F_VALID = 3'b100;
  localparam logic [2:0] F_ERR   = 3'b010;
  localparam logic [2:0] F_RPT   = 3'b001;

  ev_t  exp_q[$];
  ev_t  obs[$];
  int   rd_idx = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] exp_code = 8'h00;
  logic [7:0] exp_addr = 8'h00;

  nec_ir_rx #(.CLK_HZ(2000000), .FILT_LEN(4), .W_CNT(14)) dut (
    .clk   (clk),
    .rst   (rst),
    .ir    (ir),
    .code  (code),
    .addr  (addr),
    .valid (valid),
    .rpt   (rpt),
    .err   (err),
    .busy  (busy)
  );

  always #250 clk = ~clk;

  always @(negedge clk) begin
    if (valid || err || rpt) obs.push_back({valid, err, rpt, code, addr});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic expect_ev(input logic [2:0] f);
    exp_q.push_back({f, exp_code, exp_addr});
  endtask

  task automatic check_events(input string tag);
    ev_t e;
    #50_000;
    check({tag, "_count"}, 32'(obs.size() - rd_idx), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < obs.size()) begin
        check(tag, 32'(obs[rd_idx]), 32'(e));
        rd_idx++;
      end
    end
    rd_idx = obs.size();
  endtask

  task automatic mark(input int us);
    ir = 1'b0;
    #(us * 1000);
  endtask

  task automatic space(input int us);
    ir = 1'b1;
    #(us * 1000);
  endtask

  task automatic send_bits(input logic [31:0] wd, input int nbits);
    mark(9000);
    space(4500);
    for (int i = 0; i < nbits; i++) begin
      mark(560);
      space(wd[i] ? 1690 : 560);
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] ai,
                            input logic [7:0] c, input logic [7:0] ci);
    send_bits({ci, c, ai, a}, 32);
    mark(560);
    ir = 1'b1;
  endtask

  task automatic send_repeat();
    mark(9000);
    space(2250);
    mark(560);
    ir = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_code", 32'(code), 32'h00);
    check("rst_addr", 32'(addr), 32'h00);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_rpt", 32'(rpt), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    space(100);

    // Short low glitches on an idle line
    ir = 1'b0; #300; ir = 1'b1;
    space(50);
    ir = 1'b0; #1000; check("glitch_busy_mid", 32'(busy), 32'h0); #1000; ir = 1'b1;
    space(20);
    check("glitch_busy_after", 32'(busy), 32'h0);
    check_events("glitch_ev");

    // Nominal data frame
    send_frame(8'h00, 8'hFF, 8'h45, 8'hBA);
    exp_code = 8'h45; exp_addr = 8'h00;
    expect_ev(F_VALID);
    check_events("frame45");
    check("frame45_busy", 32'(busy), 32'h0);

    // Repeat frames, fresh and stale
    space(25000);
    send_repeat();
`ifdef IR_REPEAT_EN
    expect_ev(F_RPT);
`endif
    check_events("rpt_fresh");
    check("rpt_fresh_busy", 32'(busy), 32'h0);
`ifdef IR_REPEAT_EN
    space(188000);
    send_repeat();
    expect_ev(F_ERR);
    check_events("rpt_stale");
`endif

    // Corrupted command inverse
    space(1000);
    send_frame(8'h00, 8'hFF, 8'h45, 8'hBB);
    expect_ev(F_ERR);
    check_events("bad_inv");
    check("bad_inv_code", 32'(code), 32'h45);

    // Line stuck low after the leader
    space(1000);
    mark(9000);
    space(4500);
    ir = 1'b0;
    #11_900_000;
    check("stuck_pre_count", 32'(obs.size() - rd_idx), 32'h0);
    check("stuck_pre_busy", 32'(busy), 32'h1);
    #3_100_000;
    expect_ev(F_ERR);
    check_events("stuck_err");
    space(1000);
    check("stuck_busy_idle", 32'(busy), 32'h0);
    send_frame(8'h00, 8'hFF, 8'h16, 8'hE9);
    exp_code = 8'h16;
    expect_ev(F_VALID);
    check_events("frame16");

    // Reset during bit 20
    space(1000);
    send_bits({8'hF3, 8'h0C, 8'hFF, 8'h00}, 20);
    ir = 1'b0;
    #200_000;
    rst = 1'b1;
    #1;
    check("midrst_code", 32'(code), 32'h00);
    check("midrst_addr", 32'(addr), 32'h00);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_strobes", 32'({valid, err, rpt}), 32'h0);
    exp_code = 8'h00; exp_addr = 8'h00;
    #2000;
    rst = 1'b0;
    space(2000);
    check_events("midrst_ev");
    send_frame(8'h00, 8'hFF, 8'h0C, 8'hF3);
    exp_code = 8'h0C;
    expect_ev(F_VALID);
    check_events("frame0c");
    check("frame0c_code", 32'(code), 32'h0C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
